// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter: per-requester handshakes, FIFO write port
// and status. The arbiter uses the slave view; the environment drives through master.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
) ();
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wen;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic                          fifo_wfull;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;
  logic [15:0]                   xfer_cnt;

  modport master (
    output req_valid, req_data, fifo_wfull,
    input  req_ready, fifo_wen, fifo_wdata, grant_id, busy, xfer_cnt
  );

  modport slave (
    input  req_valid, req_data, fifo_wfull,
    output req_ready, fifo_wen, fifo_wdata, grant_id, busy, xfer_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ word streams into one FIFO write port, granting
// bursts of up to MAX_BURST words with one idle cycle between owners.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic [15:0]           xfer_cnt_q, xfer_cnt_d;
  logic [ID_W-1:0]       pick;
  logic                  any_valid;
  logic                  owner_valid;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  xfer;
  logic                  release_grant;

  assign any_valid = |bus.req_valid;

  // Scan offsets from farthest to nearest so the last hit is the first set bit at/after rr_ptr.
  always_comb begin
    int idx;
    pick = '0;
    idx  = 0;
    for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (bus.req_valid[ID_W'(idx)]) pick = ID_W'(idx);
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (ID_W'(i) == owner_q) begin
        owner_valid = bus.req_valid[i];
        owner_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Reset gates the write path directly so a burst in flight never leaks a partial write.
  assign xfer = !rst && (state_q == StBurst) && owner_valid && !bus.fifo_wfull;

  assign bus.fifo_wen   = xfer;
  assign bus.fifo_wdata = xfer ? owner_data : '0;
  assign bus.req_ready  = xfer ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.grant_id   = owner_q;
  assign bus.busy       = (state_q == StBurst);
  assign bus.xfer_cnt   = xfer_cnt_q;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    burst_cnt_d   = burst_cnt_q;
    xfer_cnt_d    = xfer_cnt_q;
    release_grant = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          owner_d     = pick;
          burst_cnt_d = '0;
          state_d     = StBurst;
        end
      end
      StBurst: begin
        // A full FIFO just stalls the burst; only the owner running dry or the cap releases it.
        if (!owner_valid) begin
          release_grant = 1'b1;
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          xfer_cnt_d  = xfer_cnt_q + 16'd1;
          if (burst_cnt_q == LAST_BEAT) release_grant = 1'b1;
        end
        if (release_grant) begin
          rr_ptr_d = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (legal range 2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, word width of each requester and of the FIFO write port.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, maximum words per grant (legal range 1..256).
REQ-004 The block SHALL have local width ID_W = $clog2(NUM_REQ).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, as the ports listed in REQ-006 and REQ-007.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester word available.
REQ-009 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester word accepted this cycle.
REQ-011 The block SHALL have port fifo_wen, output, 1 bit: write enable to the FIFO write port.
REQ-012 The block SHALL have port fifo_wdata, output, DATA_WIDTH bits: write data to the FIFO.
REQ-013 The block SHALL have port fifo_wfull, input, 1 bit: full flag from the FIFO write domain.
REQ-014 The block SHALL have port grant_id, output, ID_W bits: index of the current owner.
REQ-015 The block SHALL have port busy, output, 1 bit: high while in BURST.
REQ-016 The block SHALL have port xfer_cnt, output, 16 bits: total accepted words, wrapping modulo 2^16.

Function
REQ-017 The block SHALL implement a state machine with states IDLE and BURST, plus registers owner (ID_W bits), rr_ptr (ID_W bits) and burst_cnt ($clog2(MAX_BURST+1) bits).
REQ-018 In IDLE with any req_valid bit set, the block SHALL select the first set bit searching upward from rr_ptr with wraparound, load owner with that index, clear burst_cnt, and enter BURST on the next edge.
REQ-019 In IDLE with no req_valid bit set, the block SHALL remain in IDLE.
REQ-020 In IDLE, req_ready SHALL be 0 and fifo_wen SHALL be 0; the first transfer occurs no earlier than the cycle after the grant decision.
REQ-021 A transfer SHALL occur when state==BURST, req_valid[owner]==1 and fifo_wfull==0, all combinational in the same cycle.
REQ-022 On a transfer, the block SHALL drive fifo_wen=1, fifo_wdata=req_data[owner] and req_ready=one-hot(owner).
REQ-023 When no transfer occurs, the block SHALL drive fifo_wen=0, fifo_wdata=0 and req_ready=0.
REQ-024 Each transfer SHALL increment burst_cnt by 1 and xfer_cnt by 1.
REQ-025 The block SHALL release the grant when a transfer occurs with burst_cnt==MAX_BURST-1.
REQ-026 The block SHALL release the grant when, in BURST, req_valid[owner]==0.
REQ-027 On release, the block SHALL set rr_ptr=owner+1 modulo NUM_REQ and enter IDLE, giving one idle cycle per ownership change.
REQ-028 While fifo_wfull==1 in BURST, the block SHALL hold state, owner and burst_cnt; fifo_wfull never causes a release.
REQ-029 Requesters SHALL hold req_valid and req_data stable until req_ready; a valid bit dropped without ready is treated as "no more data".
REQ-030 grant_id SHALL equal owner at all times.
REQ-031 busy SHALL be 1 exactly when state==BURST.
REQ-032 A requester with a continuous req_valid SHALL be granted within NUM_REQ-1 other grants.

Reset
REQ-033 With rst==1 at a rising edge, the block SHALL set state=IDLE, owner=0, rr_ptr=0, burst_cnt=0 and xfer_cnt=0.
REQ-034 While rst==1, the block SHALL force fifo_wen=0, req_ready=0 and fifo_wdata=0 combinationally, even if state is still BURST.
REQ-035 After reset, the block SHALL hold busy=0 and grant_id=0.
REQ-036 Reset asserted mid-burst SHALL abandon the burst with no partial write.
REQ-037 The first arbitration after reset SHALL search from index 0.

Verification
REQ-038 The bench SHALL cover reset: rst high 2 cycles with all req_valid=1 -> fifo_wen=0, req_ready=0, busy=0, grant_id=0, xfer_cnt=0 throughout.
REQ-039 The bench SHALL cover a single requester (MAX_BURST=4): req1 valid with 6 words -> grant_id=1 one cycle later, 4 back-to-back writes, 1 idle cycle, regrant 1, 2 writes, then IDLE; xfer_cnt=6.
REQ-040 The bench SHALL cover round-robin: all 4 requesters continuously valid -> owner sequence 0,1,2,3,0, 4 words each, one idle cycle between bursts; xfer_cnt=16 after the first round.
REQ-041 The bench SHALL cover backpressure: fifo_wfull high 3 cycles after the 2nd word of a burst -> fifo_wen=0 and req_ready=0 for those 3 cycles, burst_cnt held at 2, then 2 more words and release.
REQ-042 The bench SHALL cover early release: owner 0 drops valid after 2 words while only req2 is valid -> IDLE one cycle, then grant_id=2, rr_ptr=3 after req2's release.
REQ-043 The bench SHALL cover reset mid-burst: rst asserted during owner 3's 2nd word -> fifo_wen=0 that cycle, IDLE next cycle, next grant searches from index 0.
